// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM state encoding and default frame size for the SPI frame slave.
package spi_pkg;
  localparam int FRAME_BITS_DEF = 4096;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
endpackage

// File: rtl/spi_sync.sv
// spi_sync: 2-flop synchronizer with a parameterised reset value.
module spi_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk)
    if (reset) {q, m} <= {2{RST_VAL}};
    else       {q, m} <= {m, d};
endmodule

// File: rtl/spi_frame_slave.sv
// spi_frame_slave: CPHA=0 SPI slave exchanging fixed-size frames, oversampled by clk.
module spi_frame_slave
  import spi_pkg::*;
#(
  parameter int FRAME_BITS = FRAME_BITS_DEF,
  parameter bit CPOL       = 1'b0,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sck,
  input  logic                  cs_n,
  input  logic                  sdi,
  output logic                  sdo,
  output logic [FRAME_BITS-1:0] rx_frame,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  input  logic [FRAME_BITS-1:0] tx_frame,
  input  logic                  tx_load,
  output logic                  rx_overrun,
  output logic                  rx_abort
);
  localparam int CW = $clog2(FRAME_BITS + 1);
  state_t                state;
  logic [CW-1:0]         cnt;
  logic [FRAME_BITS-1:0] tx_pend, tx_sh, rx_sh;
  logic                  sck_s, sck_d, cs_s, cs_d, sdi_s, armed;
  logic [2:0]            warm;
  logic                  lead, trail, cs_fall;
  spi_sync #(.RST_VAL(CPOL)) u_sck (.clk(clk), .reset(reset), .d(sck),  .q(sck_s));
  spi_sync #(.RST_VAL(1'b1)) u_cs  (.clk(clk), .reset(reset), .d(cs_n), .q(cs_s));
  spi_sync #(.RST_VAL(1'b0)) u_sdi (.clk(clk), .reset(reset), .d(sdi),  .q(sdi_s));
  assign lead  = (sck_s ^ sck_d) & (sck_s ^ CPOL);
  assign trail = (sck_s ^ sck_d) & ~(sck_s ^ CPOL);
  // armed only after a genuine high cs_n has been seen, so a select held low across reset is not a new frame
  assign cs_fall = armed & cs_d & ~cs_s;
  assign sdo = (state != IDLE) & (MSB_FIRST ? tx_sh[FRAME_BITS-1] : tx_sh[0]);
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      sck_d      <= CPOL;
      cs_d       <= 1'b1;
      warm       <= '0;
      armed      <= 1'b0;
      tx_pend    <= '0;
      tx_sh      <= '0;
      rx_sh      <= '0;
      rx_frame   <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      rx_abort   <= 1'b0;
    end else begin
      sck_d    <= sck_s;
      cs_d     <= cs_s;
      warm     <= {warm[1:0], 1'b1};
      armed    <= armed | (warm[2] & cs_s);
      rx_abort <= 1'b0;
      if (tx_load) tx_pend <= tx_frame;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      case (state)
        IDLE: if (cs_fall) state <= LOAD;
        LOAD: begin
          tx_sh <= tx_load ? tx_frame : tx_pend;
          cnt   <= '0;
          rx_sh <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          if (cs_s) begin
            rx_abort <= 1'b1;
            state    <= IDLE;
          end else begin
            if (lead && cnt != CW'(FRAME_BITS)) begin
              rx_sh <= MSB_FIRST ? {rx_sh[FRAME_BITS-2:0], sdi_s} : {sdi_s, rx_sh[FRAME_BITS-1:1]};
              cnt   <= cnt + CW'(1);
              if (cnt == CW'(FRAME_BITS - 1)) state <= DONE;
            end
            if (trail) tx_sh <= MSB_FIRST ? tx_sh << 1 : tx_sh >> 1;
          end
        end
        DONE: begin
          rx_frame   <= rx_sh;
          rx_valid   <= 1'b1;
          rx_overrun <= rx_overrun | (rx_valid & ~rx_ready);
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
